// File: rtl/dma_channel_scheduler_if.sv
// Descriptor submit and engine issue bundle for dma_channel_scheduler.
//   submit_* : software/CPU side offers one descriptor per channel (valid/ready)
//   engine_* : scheduler issues one descriptor at a time to the DMA engine
//              (valid/ready) and receives done/error completion pulses
// modport slave  : the scheduler
// modport master : the environment (descriptor source plus DMA engine)
interface dma_channel_scheduler_if #(
  parameter int unsigned ChannelsCount = 4,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned LengthWidth   = 16
);
  localparam int unsigned CW = (ChannelsCount > 1) ? $clog2(ChannelsCount) : 1;

  logic                    submit_valid;
  logic                    submit_ready;
  logic [CW-1:0]           submit_channel;
  logic [AddressWidth-1:0] submit_src;
  logic [AddressWidth-1:0] submit_dst;
  logic [LengthWidth-1:0]  submit_len;

  logic                    engine_valid;
  logic                    engine_ready;
  logic [CW-1:0]           engine_channel;
  logic [AddressWidth-1:0] engine_src;
  logic [AddressWidth-1:0] engine_dst;
  logic [LengthWidth-1:0]  engine_len;
  logic                    engine_done;
  logic                    engine_error;

  modport slave (
    input  submit_valid, submit_channel, submit_src, submit_dst, submit_len,
    output submit_ready,
    output engine_valid, engine_channel, engine_src, engine_dst, engine_len,
    input  engine_ready, engine_done, engine_error
  );

  modport master (
    output submit_valid, submit_channel, submit_src, submit_dst, submit_len,
    input  submit_ready,
    input  engine_valid, engine_channel, engine_src, engine_dst, engine_len,
    output engine_ready, engine_done, engine_error
  );
endinterface

// File: rtl/dma_channel_scheduler.sv
// Multi-channel front end for a single-engine DMA core.
// Holds one descriptor per channel, arbitrates pending channels round-robin
// and issues them to the engine one at a time; reports sticky per-channel
// done/error status as maskable level interrupts.
// Ports:
//   clk, areset_n : clock (posedge) and asynchronous active-low reset
//   bus           : submit/engine handshakes (dma_channel_scheduler_if.slave)
//   irq_mask      : 1 = interrupt enabled for that channel
//   irq_clear     : write-one-to-clear pulse for done_status/error_status
//   busy          : channel slot is not idle
//   done_status   : sticky completion flags
//   error_status  : sticky error flags
//   interrupts    : (done_status | error_status) & irq_mask, combinational
module dma_channel_scheduler #(
  parameter int unsigned ChannelsCount = 4,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned LengthWidth   = 16
) (
  input  logic                     clk,
  input  logic                     areset_n,
  dma_channel_scheduler_if.slave   bus,
  input  logic [ChannelsCount-1:0] irq_mask,
  input  logic [ChannelsCount-1:0] irq_clear,
  output logic [ChannelsCount-1:0] busy,
  output logic [ChannelsCount-1:0] done_status,
  output logic [ChannelsCount-1:0] error_status,
  output logic [ChannelsCount-1:0] interrupts
);
  localparam int unsigned CW = (ChannelsCount > 1) ? $clog2(ChannelsCount) : 1;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_PENDING,
    SLOT_ACTIVE
  } slot_e;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_ISSUE,
    SCHED_WAIT
  } sched_e;

  // Per-channel descriptor slots
  slot_e                   slot_q [ChannelsCount];
  logic [AddressWidth-1:0] src_q  [ChannelsCount];
  logic [AddressWidth-1:0] dst_q  [ChannelsCount];
  logic [LengthWidth-1:0]  len_q  [ChannelsCount];

  // Scheduler state
  sched_e                  state_q, state_d;
  logic [CW-1:0]           rr_q;
  logic [CW-1:0]           eng_ch_q;
  logic [AddressWidth-1:0] eng_src_q;
  logic [AddressWidth-1:0] eng_dst_q;
  logic [LengthWidth-1:0]  eng_len_q;
  logic                    init_q;

  // Combinational controls
  logic                     ch_idle;
  logic                     submit_ready;
  logic                     accept;
  logic                     accept_zero;
  logic                     grant_valid;
  logic [CW-1:0]            grant_ch;
  int unsigned              arb_idx;
  logic                     eng_valid;
  logic                     load_eng;
  logic                     issue_hs;
  logic                     complete;
  logic [ChannelsCount-1:0] done_set;
  logic [ChannelsCount-1:0] err_set;

  // Selected slot idle; a channel number beyond ChannelsCount never matches,
  // so out-of-range submissions are never ready.
  always_comb begin
    ch_idle = 1'b0;
    for (int unsigned i = 0; i < ChannelsCount; i++) begin
      if (bus.submit_channel == CW'(i)) begin
        ch_idle = (slot_q[i] == SLOT_IDLE);
      end
    end
  end

  // init_q keeps submit_ready low until the first clock after reset release.
  assign submit_ready     = init_q && ch_idle;
  assign bus.submit_ready = submit_ready;
  assign accept           = bus.submit_valid && submit_ready;
  assign accept_zero      = accept && (bus.submit_len == '0);

  // Round-robin pick: first PENDING slot at or after rr_q, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    arb_idx     = 0;
    for (int unsigned i = 0; i < ChannelsCount; i++) begin
      arb_idx = 32'(rr_q) + i;
      if (arb_idx >= ChannelsCount) begin
        arb_idx = arb_idx - ChannelsCount;
      end
      if (!grant_valid && (slot_q[CW'(arb_idx)] == SLOT_PENDING)) begin
        grant_valid = 1'b1;
        grant_ch    = CW'(arb_idx);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= SCHED_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCHED_IDLE:  if (grant_valid)      state_d = SCHED_ISSUE;
      SCHED_ISSUE: if (bus.engine_ready) state_d = SCHED_WAIT;
      SCHED_WAIT:  if (bus.engine_done)  state_d = SCHED_IDLE;
      default:                           state_d = SCHED_IDLE;
    endcase
  end

  // FSM: outputs and strobes
  always_comb begin
    eng_valid = 1'b0;
    load_eng  = 1'b0;
    issue_hs  = 1'b0;
    complete  = 1'b0;
    case (state_q)
      SCHED_IDLE:  load_eng = grant_valid;
      SCHED_ISSUE: begin
        eng_valid = 1'b1;
        issue_hs  = bus.engine_ready;
      end
      SCHED_WAIT:  complete = bus.engine_done;
      default:     ;
    endcase
  end

  assign bus.engine_valid   = eng_valid;
  assign bus.engine_channel = eng_ch_q;
  assign bus.engine_src     = eng_src_q;
  assign bus.engine_dst     = eng_dst_q;
  assign bus.engine_len     = eng_len_q;

  // Status set terms: zero-length accept completes immediately; engine_done
  // only counts while waiting on the in-flight transfer.
  always_comb begin
    done_set = '0;
    err_set  = '0;
    for (int unsigned i = 0; i < ChannelsCount; i++) begin
      done_set[i] = (accept_zero && (bus.submit_channel == CW'(i))) ||
                    (complete && (eng_ch_q == CW'(i)));
      err_set[i]  = complete && bus.engine_error && (eng_ch_q == CW'(i));
    end
  end

  // Slots, engine descriptor registers, rr pointer and status flags
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int unsigned i = 0; i < ChannelsCount; i++) begin
        slot_q[i] <= SLOT_IDLE;
        src_q[i]  <= '0;
        dst_q[i]  <= '0;
        len_q[i]  <= '0;
      end
      init_q       <= 1'b0;
      rr_q         <= '0;
      eng_ch_q     <= '0;
      eng_src_q    <= '0;
      eng_dst_q    <= '0;
      eng_len_q    <= '0;
      done_status  <= '0;
      error_status <= '0;
    end else begin
      init_q <= 1'b1;
      for (int unsigned i = 0; i < ChannelsCount; i++) begin
        if (accept && (bus.submit_channel == CW'(i))) begin
          src_q[i] <= bus.submit_src;
          dst_q[i] <= bus.submit_dst;
          len_q[i] <= bus.submit_len;
          if (!accept_zero) begin
            slot_q[i] <= SLOT_PENDING;
          end
        end else if (issue_hs && (eng_ch_q == CW'(i))) begin
          slot_q[i] <= SLOT_ACTIVE;
        end else if (complete && (eng_ch_q == CW'(i))) begin
          slot_q[i] <= SLOT_IDLE;
        end
      end

      if (load_eng) begin
        eng_ch_q  <= grant_ch;
        eng_src_q <= src_q[grant_ch];
        eng_dst_q <= dst_q[grant_ch];
        eng_len_q <= len_q[grant_ch];
      end

      if (issue_hs) begin
        rr_q <= (eng_ch_q == CW'(ChannelsCount - 1)) ? '0 : eng_ch_q + 1'b1;
      end

      // Set wins over a simultaneous W1C clear.
      done_status  <= (done_status  & ~irq_clear) | done_set;
      error_status <= (error_status & ~irq_clear) | err_set;
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < ChannelsCount; i++) begin
      busy[i] = (slot_q[i] != SLOT_IDLE);
    end
  end

  assign interrupts = (done_status | error_status) & irq_mask;

endmodule
